// File: rtl/counter_cmd_pkg.sv
// Shared types and command encodings for the counter command transmitter.
package counter_cmd_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } cmd_state_e;

  localparam logic [CMD_W-1:0] CMD_HOLD = 2'b00;
  localparam logic [CMD_W-1:0] CMD_INCR = 2'b01;
  localparam logic [CMD_W-1:0] CMD_DECR = 2'b10;

endpackage

// File: rtl/counter_cmd_gap_timer.sv
// Inter-beat idle timer: after a load of value V, expired rises on the V-th cycle.
module counter_cmd_gap_timer #(
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             expired
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  // Loading V-1 makes the count-to-zero span exactly V cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = GAP_W'(value - 1'b1);
    end else if (cnt_q != '0) begin
      cnt_d = GAP_W'(cnt_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/counter_cmd_tx.sv
// Burst command transmitter driving increment/decrement beats into the counter,
// with abort on counter error.
module counter_cmd_tx
  import counter_cmd_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             start_dir,
  input  logic [LEN_W-1:0] start_len,
  input  logic [GAP_W-1:0] start_gap,
  output logic             valid,
  output logic [1:0]       in,
  input  logic             incr_decr_error,
  output logic             busy,
  output logic             done,
  output logic             err_seen,
  output logic [LEN_W-1:0] beats_sent
);

  cmd_state_e       state_q, state_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [1:0]       in_q, in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gap_load;
  logic             gap_expired;

  counter_cmd_gap_timer #(
    .GAP_W(GAP_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .value  (gap_q),
    .expired(gap_expired)
  );

  assign start_ready = ~rst & (state_q == IDLE);

  // Next state; beats_q already includes the beat of the current SEND cycle.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    len_d    = len_q;
    gap_d    = gap_q;
    beats_d  = beats_q;
    err_d    = err_q;
    gap_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          dir_d   = start_dir;
          len_d   = start_len;
          gap_d   = start_gap;
          beats_d = '0;
          err_d   = 1'b0;
          state_d = (start_len == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (incr_decr_error) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (beats_q == len_q) begin
          state_d = DONE;
        end else if (gap_q != '0) begin
          gap_load = 1'b1;
          state_d  = GAP;
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        if (incr_decr_error) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (gap_expired) begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A beat is counted on entry to every SEND cycle, saturating at all-ones.
    if (state_d == SEND && beats_d != '1) begin
      beats_d = LEN_W'(beats_d + 1'b1);
    end

    valid_d = (state_d == SEND);
    in_d    = (state_d == SEND) ? (dir_d ? CMD_DECR : CMD_INCR) : CMD_HOLD;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      len_q   <= '0;
      gap_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      in_q    <= CMD_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      beats_q <= beats_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid      = valid_q;
  assign in         = in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_seen   = err_q;
  assign beats_sent = beats_q;

endmodule

// File: doc/counter_cmd_tx.md
# counter_cmd_tx

Hardware command transmitter for the `counter` block's `valid`/`in` input port. Accepts a burst request (direction, beat count, inter-beat gap) over a ready/valid handshake, then drives increment or decrement beats into the counter. While busy, it watches `incr_decr_error` and aborts the burst on an error. It sits in front of `counter` in place of the testbench BFM, so the same counter can be exercised from on-chip logic.

## Interface
Parameters:
- `LEN_W`, 8: width of the beat-count field and of `beats_sent`.
- `GAP_W`, 4: width of the inter-beat idle-cycle field.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  a burst request is present.
- `start_ready`  out  1  the block can accept a request; high only in IDLE, low while `rst`=1.
- `start_dir`  in  1  0 = increment, 1 = decrement.
- `start_len`  in  LEN_W  number of beats in the burst; 0 is legal.
- `start_gap`  in  GAP_W  idle cycles inserted between beats.
- `valid`  out  1  a beat is present on `in` (connects to counter `valid`).
- `in`  out  2  command to the counter: 2'b00 hold, 2'b01 incr, 2'b10 decr; 2'b11 is never driven.
- `incr_decr_error`  in  1  error indication from the counter.
- `busy`  out  1  a burst is in progress (SEND, GAP or DONE).
- `done`  out  1  one-cycle pulse when a burst ends, whether completed or aborted.
- `err_seen`  out  1  the last burst was aborted; sticky until the next accepted start.
- `beats_sent`  out  LEN_W  number of beats issued in the current or last burst.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - A request is accepted when `start_valid & start_ready`.
  - On accept, latch `dir`, `len` and `gap`; clear `beats_sent` and `err_seen`.
  - If `len`=0, go to DONE. Otherwise go to SEND.
- SEND:
  - Drive `valid`=1 and `in`=01 or 10 according to the latched `dir`, for exactly one cycle.
  - `beats_sent` increments on that cycle.
  - If this is the last beat, go to DONE.
  - Otherwise, if `gap`>0 go to GAP; if `gap`=0 stay in SEND, so beats are back-to-back.
- GAP:
  - Drive `valid`=0, `in`=00 for `gap` cycles, using a down-counter loaded on leaving SEND.
  - When the down-counter reaches 0, return to SEND.
- DONE:
  - Hold for one cycle with `done`=1, then return to IDLE.
- Error abort:
  - `incr_decr_error` is sampled in every SEND and GAP cycle.
  - If it is high, set `err_seen`=1 and go to DONE next cycle. No further beats are issued, including any beat that would otherwise occur on that next cycle.
  - `incr_decr_error` is ignored in IDLE and DONE.
- Last beat with error in the same cycle: the beat is counted, then the block goes to DONE with `err_seen`=1.
- `beats_sent` saturates at `2^LEN_W-1`. It cannot exceed `len` by construction.
- Request fields are ignored outside the accept cycle. Changing them mid-burst has no effect.

## Timing
- Reset: while `rst`=1, on every clock edge:
  - state = IDLE;
  - `valid`, `in`, `busy`, `done`, `err_seen` and `beats_sent` all go to 0;
  - `start_ready` is held at 0.
- Reset mid-burst: the burst is abandoned immediately. No `done` pulse is produced.
- First cycle after `rst` falls: `start_ready`=1.
- Accept at edge N: first beat on `valid` in cycle N+1; `busy` is 1 from N+1.
- Beat spacing: `gap`+1 cycles between consecutive beats.
- Burst duration: last beat at cycle N+1+(`len`-1)·(`gap`+1); `done` pulses the cycle after the last beat.
- `len`=0: `done` pulses at N+1; `valid` never rises.
- Back-to-back bursts: the earliest next accept is the cycle after `done`. IDLE always lasts at least one cycle.
- All outputs are registered, except `start_ready`, which is a decode of the state and `rst`.

## Structure
- Package `counter_cmd_pkg`:
  - state enum `cmd_state_e` (IDLE, SEND, GAP, DONE);
  - constants `CMD_HOLD`=2'b00, `CMD_INCR`=2'b01, `CMD_DECR`=2'b10.
- Sub-module `counter_cmd_gap_timer`: a GAP_W down-counter with `load`/`value` inputs and an `expired` output, instantiated once.
- The FSM, beat counter and sticky error flag live in `counter_cmd_tx`.

## Test plan
- Reset, then idle → all outputs 0; `start_ready`=1 from the first cycle after `rst` falls.
- Request `dir`=0, `len`=4, `gap`=0 → `valid` high for 4 consecutive cycles with `in`=01; `beats_sent`=4; `done` pulses once; `err_seen`=0.
- Request `dir`=1, `len`=3, `gap`=2 → beats with `in`=10 at cycles N+1, N+4, N+7; `valid`=0 in between; `done` at N+8.
- Request `len`=0 → no beat; `done` at N+1; back in IDLE at N+2.
- Request `len`=10, `gap`=1, `incr_decr_error` forced high in the cycle after beat 3 → no beat 4; `beats_sent`=3; `err_seen`=1; `done` one cycle later. A subsequent accepted request clears `err_seen`.
- `rst` pulsed during the GAP of a `len`=5 burst → outputs 0 on the next cycle; no `done` pulse; a new request is accepted normally afterwards.
